// File: rtl/input_conditioner_if.sv
// Bundle of raw inputs, per-channel mode select and conditioned outputs
// exchanged between the FSM front end and the conditioner.
interface input_conditioner_if #(
    parameter int N_CH = 3
);
    logic [N_CH-1:0] raw;
    logic [N_CH-1:0] mode;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] busy;
    logic [N_CH-1:0] q;

    modport master (
        output raw,
        output mode,
        input  level,
        input  rise,
        input  fall,
        input  busy,
        input  q
    );

    modport slave (
        input  raw,
        input  mode,
        output level,
        output rise,
        output fall,
        output busy,
        output q
    );
endinterface

// File: rtl/input_conditioner.sv
// Per-channel 2-FF synchroniser plus counter debouncer for the lab FSM inputs;
// presents each channel as a clean level or a single-cycle rise pulse.
module input_conditioner #(
    parameter int N_CH            = 3,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic                clk,
    input logic                n_reset,
    input_conditioner_if.slave bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // The state is a view of {level, counter busy}; no separate state register.
    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        QUAL_HI   = 2'b01,
        STABLE_HI = 2'b10,
        QUAL_LO   = 2'b11
    } deb_state_e;

    logic [N_CH-1:0]  sync1_q;
    logic [N_CH-1:0]  sync2_q;
    logic [N_CH-1:0]  level_q;
    logic [N_CH-1:0]  level_d;
    logic [N_CH-1:0]  rise_q;
    logic [N_CH-1:0]  rise_d;
    logic [N_CH-1:0]  fall_q;
    logic [N_CH-1:0]  fall_d;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    deb_state_e       state [N_CH];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            cnt_d[ch] = cnt_q[ch];
            state[ch] = deb_state_e'({level_q[ch], cnt_q[ch] != '0});
            case (state[ch])
                STABLE_LO, STABLE_HI: begin
                    // A differing sample is the first of the qualifying run.
                    cnt_d[ch] = (sync2_q[ch] != level_q[ch]) ? CNT_W'(1) : '0;
                end
                QUAL_HI, QUAL_LO: begin
                    if (sync2_q[ch] == level_q[ch]) begin
                        cnt_d[ch] = '0;
                    end else if (cnt_q[ch] == CNT_MAX) begin
                        level_d[ch] = sync2_q[ch];
                        rise_d[ch]  = sync2_q[ch];
                        fall_d[ch]  = ~sync2_q[ch];
                        cnt_d[ch]   = '0;
                    end else begin
                        cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
                    end
                end
                default: cnt_d[ch] = '0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: all state, including the synchroniser and counters, resets asynchronously; a partial count is discarded.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int ch = 0; ch < N_CH; ch++) begin
                cnt_q[ch] <= '0;
            end
        end else begin
            // sync1 may go metastable; only sync2 is allowed to fan out.
            sync1_q <= bus.raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int ch = 0; ch < N_CH; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
        end
    end

    always_comb begin
        bus.busy = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            bus.busy[ch] = (cnt_q[ch] != '0);
        end
    end

    assign bus.level = level_q;
    assign bus.rise  = rise_q;
    assign bus.fall  = fall_q;
    assign bus.q     = (bus.mode & rise_q) | (~bus.mode & level_q);

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: stimulus queues expected pulse events,
// a negedge monitor pops and compares them and flags any unexpected pulse.
module tb_input_conditioner;

    localparam int N_CH = 3;
    localparam int DEB  = 4;
    localparam int LAT  = DEB + 1;  // edges from sync1 capture to level change

    logic clk = 1'b0;
    logic n_reset;

    always #5 clk = ~clk;

    input_conditioner_if #(.N_CH(N_CH)) bus ();

    input_conditioner #(
        .N_CH           (N_CH),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk    (clk),
        .n_reset(n_reset),
        .bus    (bus)
    );

    typedef struct {
        int              cyc;
        logic [N_CH-1:0] rise;
        logic [N_CH-1:0] fall;
        logic [N_CH-1:0] level;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    endtask

    task automatic expect_event(input int cyc, input logic [N_CH-1:0] r,
                                input logic [N_CH-1:0] f, input logic [N_CH-1:0] l);
        exp_t e;
        e.cyc   = cyc;
        e.rise  = r;
        e.fall  = f;
        e.level = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_edge(input int k);
        while (edge_cnt < k) @(negedge clk);
    endtask

    // Monitor: pulses are only legal on edges the stimulus announced.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc < edge_cnt) begin
            check("missed_event_edge", edge_cnt, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == edge_cnt) begin
            mon_e = exp_q.pop_front();
            check("event_rise",  bus.rise,  mon_e.rise);
            check("event_fall",  bus.fall,  mon_e.fall);
            check("event_level", bus.level, mon_e.level);
        end else if ((bus.rise | bus.fall) != '0) begin
            check("spurious_pulse_rise_fall", {bus.rise, bus.fall}, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int              e;
        int              r;
        logic [N_CH-1:0] lvl;
        logic            pat [5];
        int              dev_left [N_CH];
        bit              rest [N_CH];

        n_reset  = 1'b0;
        bus.raw  = '0;
        bus.mode = '0;
        repeat (3) @(negedge clk);
        check("reset_level", bus.level, 0);
        check("reset_rise",  bus.rise,  0);
        check("reset_fall",  bus.fall,  0);
        check("reset_busy",  bus.busy,  0);
        check("reset_q",     bus.q,     0);
        n_reset = 1'b1;
        repeat (2) @(negedge clk);

        // 1: clean rise on A, first in pulse mode, then level mode
        bus.mode[0] = 1'b1;
        bus.raw[0]  = 1'b1;
        e   = edge_cnt;
        lvl = 3'b001;
        expect_event(e + 1 + LAT, 3'b001, 3'b000, lvl);
        wait_edge(e + 3);
        check("t1_busy_qualifying", bus.busy[0], 1);
        wait_edge(e + LAT);
        check("t1_level_not_yet", bus.level[0], 0);
        wait_edge(e + 1 + LAT);
        check("t1_q_pulse_mode", bus.q[0], 1);
        @(negedge clk);
        check("t1_q_after_pulse", bus.q[0], 0);
        bus.mode[0] = 1'b0;
        #1;
        check("t1_q_level_mode", bus.q[0], 1);
        check("t1_busy_idle", bus.busy[0], 0);

        // 2: bounce 1,0,1,0,1 on B then held high
        @(negedge clk);
        e = edge_cnt;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0; pat[4] = 1'b1;
        lvl = 3'b011;
        expect_event(e + 5 + LAT, 3'b010, 3'b000, lvl);
        for (int i = 0; i < 5; i++) begin
            bus.raw[1] = pat[i];
            @(negedge clk);
        end
        wait_edge(e + 4 + LAT);
        check("t2_level_not_yet", bus.level[1], 0);
        wait_edge(e + 5 + LAT);
        check("t2_q_level_mode", bus.q[1], 1);
        @(negedge clk);
        check("t2_busy_idle", bus.busy[1], 0);

        // 3: three-cycle glitch on C never qualifies
        @(negedge clk);
        e = edge_cnt;
        bus.raw[2] = 1'b1;
        wait_edge(e + 3);
        bus.raw[2] = 1'b0;
        wait_edge(e + 4);
        check("t3_busy_during_glitch", bus.busy[2], 1);
        wait_edge(e + 8);
        check("t3_busy_after_glitch", bus.busy[2], 0);
        check("t3_level_unchanged", bus.level[2], 0);

        // 4: all high, then A and C fall together while B holds
        @(negedge clk);
        e = edge_cnt;
        bus.raw[2] = 1'b1;
        lvl = 3'b111;
        expect_event(e + 1 + LAT, 3'b100, 3'b000, lvl);
        wait_edge(e + 3 + LAT);
        e = edge_cnt;
        bus.raw[0] = 1'b0;
        bus.raw[2] = 1'b0;
        lvl = 3'b010;
        expect_event(e + 1 + LAT, 3'b000, 3'b101, lvl);
        wait_edge(e + 3);
        check("t4_busy_two_channels", bus.busy, 3'b101);
        wait_edge(e + 2 + LAT);
        check("t4_level_after_fall", bus.level, 3'b010);
        check("t4_busy_idle", bus.busy, 0);

        // 5: reset in the middle of qualifying A, released with A and B high
        @(negedge clk);
        e = edge_cnt;
        bus.raw[0] = 1'b1;
        wait_edge(e + 3);
        check("t5_busy_before_reset", bus.busy[0], 1);
        #2 n_reset = 1'b0;
        bus.mode = 3'b111;
        #1;
        check("t5_reset_level", bus.level, 0);
        check("t5_reset_rise",  bus.rise,  0);
        check("t5_reset_fall",  bus.fall,  0);
        check("t5_reset_busy",  bus.busy,  0);
        check("t5_reset_q",     bus.q,     0);
        bus.mode = 3'b000;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        r   = edge_cnt;
        lvl = 3'b011;
        expect_event(r + 6, 3'b011, 3'b000, lvl);
        wait_edge(r + 5);
        check("t5_level_not_yet", bus.level, 0);
        wait_edge(r + 8);

        // 6: 200 cycles of short deviations (1-3 cycles) on every channel
        for (int c = 0; c < N_CH; c++) begin
            dev_left[c] = 0;
            rest[c]     = 1'b0;
        end
        for (int cyc = 0; cyc < 200; cyc++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (dev_left[c] == 0 && !rest[c] && $urandom_range(0, 1) == 1)
                    dev_left[c] = int'($urandom_range(1, 3));
                if (dev_left[c] > 0) begin
                    bus.raw[c] = ~lvl[c];
                    dev_left[c]--;
                    rest[c] = (dev_left[c] == 0);
                end else begin
                    bus.raw[c] = lvl[c];
                    rest[c]    = 1'b0;
                end
            end
            @(negedge clk);
        end
        bus.raw = lvl;
        repeat (8) @(negedge clk);
        check("t6_level_held", bus.level, lvl);
        check("t6_busy_idle", bus.busy, 0);

        repeat (2) @(negedge clk);
        check("event_queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
